simplebus_mem_slave: RTL
========================

SIMPLEBUS_MEM_SLAVE -- requirements
Module: simplebus_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, depth of the backing store in 64-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to first resp_valid (legal range 1..15).
REQ-003 SHALL have the following ports:
- clk  in  1  clock; sole clock, all state on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_ready  out  1  slave can accept a request beat.
- req_valid  in  1  request beat present.
- req_bits_addr  in  32  byte address.
- req_bits_size  in  3  access size; carried, not decoded.
- req_bits_cmd  in  4  command.
- req_bits_wmask  in  8  byte write enables.
- req_bits_wdata  in  64  write data.
- req_bits_user  in  16  tag returned with the response.
- resp_ready  in  1  master accepts a response beat.
- resp_valid  out  1  response beat present.
- resp_bits_cmd  out  4  response command.
- resp_bits_rdata  out  64  read data.
- resp_bits_user  out  16  latched request user tag.

Function
REQ-004 A beat SHALL transfer (fire) on any rising edge where valid and ready are both 1; both channels SHALL use this rule.
REQ-005 Word index SHALL be addr[3+log2(MEM_WORDS)-1:3]; higher address bits SHALL be ignored (aliasing).
REQ-006 The FSM SHALL have states IDLE, WBURST, WAIT and RESP; req_ready SHALL be 1 only in IDLE and WBURST; resp_valid SHALL be 1 only in RESP.
REQ-007 In IDLE, on fire the block SHALL latch the word index, cmd and user.
- read (0): go to WAIT.
- write (1): byte-masked write of wdata at fire, then WAIT.
- readBurst (2): go to WAIT.
- writeBurst (3): write beat 0 at fire, then WBURST.
- writeLast (7): single masked write, then WAIT.
- Any other cmd: go to WAIT with no memory effect.
REQ-008 In WBURST, each fire SHALL perform a masked write at line base + (beat count mod 4), with the index wrapping within the 4-word line; cmd 3 SHALL stay in WBURST and cmd 7 SHALL go to WAIT.
REQ-009 WAIT SHALL last exactly LATENCY-1 cycles, so resp_valid rises LATENCY cycles after the accepting edge.
REQ-010 RESP for read SHALL give one beat: cmd readLast (6), rdata = mem[index].
REQ-011 RESP for readBurst SHALL give 4 beats at {index[hi:2], index[1:0]+i} for i=0..3 (critical-word-first, wrap within the line).
- Beats 0-2: cmd read (0).
- Beat 3: cmd readLast (6).
REQ-012 RESP for write, writeLast or writeBurst SHALL give one beat: cmd writeResp (5), rdata 0.
REQ-013 RESP for an unsupported cmd SHALL give one beat: cmd readLast (6), rdata 0.
REQ-014 While resp_valid=1 and resp_ready=0, all resp_bits SHALL hold stable; resp_valid SHALL NOT drop before fire.
REQ-015 The block SHALL advance one beat per response fire; fire of the final beat SHALL return the FSM to IDLE.
REQ-016 req_ready SHALL NOT be asserted on the cycle the final beat fires, so there is no request/response overlap; the next request is accepted in IDLE at the earliest one cycle later.
REQ-017 resp_bits_user SHALL equal the user latched at the first request beat for every response beat.
REQ-018 A read issued after a completed write to the same word SHALL return the written data.

Reset
REQ-019 On rst=0, asynchronously:
- FSM SHALL go to IDLE.
- Counters SHALL clear.
- req_ready SHALL be 1 and resp_valid SHALL be 0.
- resp_bits_cmd, resp_bits_rdata and resp_bits_user SHALL be 0.
REQ-020 Memory contents SHALL NOT be cleared by reset; reset mid-burst or mid-wait SHALL abandon the transaction with no further writes.

Structure
REQ-021 Command encodings (read 0, write 1, readBurst 2, writeBurst 3, writeResp 5, readLast 6, writeLast 7) and the FSM state enum SHALL live in package simplebus_pkg.
REQ-022 The byte-masked 64-bit RAM SHALL be sub-module simplebus_mem_array (synchronous write, combinational read, MEM_WORDS deep).

Verification
REQ-023 write addr 0x40, wdata 0x1122334455667788, wmask 0xFF, user 0x5 -> after 2 cycles, resp cmd 5, user 0x5; then read 0x40 -> rdata 0x1122334455667788, cmd 6.
REQ-024 wmask 0x0F write of 0xAAAAAAAAAAAAAAAA over 0x1122334455667788 at 0x40 -> read returns 0x11223344AAAAAAAA.
REQ-025 readBurst addr 0x50 after words 0x40..0x58 are preloaded with 0..3 -> beats rdata 2,3,0,1 with cmds 0,0,0,6.
REQ-026 resp_ready held 0 for 5 cycles during burst beat 1 -> beat 1 is held stable, no beat is skipped or duplicated, and req_ready=0 throughout.
REQ-027 writeBurst of 4 beats (cmds 3,3,3,7) at 0x80 with data A,B,C,D -> single resp cmd 5, and a readBurst at 0x80 returns A,B,C,D.
REQ-028 rst pulled low in WAIT of a read -> resp_valid=0 and req_ready=1 immediately; after release, a new read completes normally with memory intact.

Source files
------------

// File: rtl/simplebus_pkg.sv
// Shared command encodings, FSM state type and response-decode helpers for the
// simplebus memory slave.
package simplebus_pkg;

   localparam logic [3:0] CMD_READ        = 4'd0;
   localparam logic [3:0] CMD_WRITE       = 4'd1;
   localparam logic [3:0] CMD_READ_BURST  = 4'd2;
   localparam logic [3:0] CMD_WRITE_BURST = 4'd3;
   localparam logic [3:0] CMD_WRITE_RESP  = 4'd5;
   localparam logic [3:0] CMD_READ_LAST   = 4'd6;
   localparam logic [3:0] CMD_WRITE_LAST  = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WBURST,
      ST_WAIT,
      ST_RESP
   } state_t;

   function automatic logic is_write(input logic [3:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_BURST) || (cmd == CMD_WRITE_LAST);
   endfunction

   function automatic logic has_rdata(input logic [3:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_READ_BURST);
   endfunction

   // Response command for a given request command and response beat number.
   function automatic logic [3:0] resp_cmd(input logic [3:0] cmd, input logic [1:0] beat);
      if (is_write(cmd))
         return CMD_WRITE_RESP;
      if ((cmd == CMD_READ_BURST) && (beat != 2'd3))
         return CMD_READ;
      return CMD_READ_LAST;
   endfunction

endpackage

// File: rtl/simplebus_mem_array.sv
// Byte-masked 64-bit RAM: synchronous write, combinational read, no reset so
// contents survive a bus reset.
module simplebus_mem_array #(
   parameter int WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [$clog2(WORDS)-1:0]  waddr,
   input  logic [7:0]                wmask,
   input  logic [63:0]               wdata,
   input  logic [$clog2(WORDS)-1:0]  raddr,
   output logic [63:0]               rdata
);

   logic [63:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask[b])
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simplebus_mem_slave.sv
// Simplebus memory slave: accepts single/burst requests, waits a fixed latency,
// then returns one or four response beats.
//
// state  | meaning
// IDLE   | ready for the first request beat
// WBURST | collecting write-burst beats until writeLast
// WAIT   | fixed access latency countdown
// RESP   | presenting response beats until the last one fires
module simplebus_mem_slave import simplebus_pkg::*; #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_ready,
   input  logic        req_valid,
   input  logic [31:0] req_bits_addr,
   input  logic [2:0]  req_bits_size,
   input  logic [3:0]  req_bits_cmd,
   input  logic [7:0]  req_bits_wmask,
   input  logic [63:0] req_bits_wdata,
   input  logic [15:0] req_bits_user,
   input  logic        resp_ready,
   output logic        resp_valid,
   output logic [3:0]  resp_bits_cmd,
   output logic [63:0] resp_bits_rdata,
   output logic [15:0] resp_bits_user
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   state_t        state;
   logic [IW-1:0] idx_q;
   logic [3:0]    cmd_q;
   logic [15:0]   user_q;
   logic [1:0]    beat_q;
   logic [3:0]    wait_q;

   logic          req_fire, resp_fire, last_beat, to_wait, load_resp;
   logic [IW-1:0] req_idx, mem_waddr, mem_raddr;
   logic          mem_we;
   logic [63:0]   mem_rdata;
   logic [1:0]    nxt_beat, rd_lo;
   logic [3:0]    src_cmd;
   logic          unused_bits;

   assign req_fire    = req_valid & req_ready;
   assign resp_fire   = resp_valid & resp_ready;
   assign req_idx     = req_bits_addr[3 +: IW];
   assign unused_bits = ^{req_bits_size, req_bits_addr[31:3+IW], req_bits_addr[2:0]};
   assign last_beat   = (cmd_q != CMD_READ_BURST) || (beat_q == 2'd3);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = req_idx;
      to_wait   = 1'b0;
      case (state)
         ST_IDLE: begin
            mem_we  = req_fire && is_write(req_bits_cmd);
            to_wait = req_fire && (req_bits_cmd != CMD_WRITE_BURST);
         end
         ST_WBURST: begin
            mem_we    = req_fire;
            mem_waddr = {idx_q[IW-1:2], beat_q};
            to_wait   = req_fire && (req_bits_cmd == CMD_WRITE_LAST);
         end
         default: ;
      endcase
   end

   // Next response payload: beat 0 on entry to RESP, beat+1 on an intermediate fire.
   always_comb begin
      nxt_beat  = (state == ST_RESP) ? beat_q + 2'd1 : 2'd0;
      rd_lo     = idx_q[1:0] + nxt_beat;
      mem_raddr = (state == ST_IDLE) ? req_idx : {idx_q[IW-1:2], rd_lo};
      src_cmd   = (state == ST_IDLE) ? req_bits_cmd : cmd_q;
      load_resp = (to_wait && (LATENCY == 1))
               || ((state == ST_WAIT) && (wait_q == 4'd0))
               || ((state == ST_RESP) && resp_fire && !last_beat);
   end

   simplebus_mem_array #(.WORDS(MEM_WORDS)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wmask (req_bits_wmask),
      .wdata (req_bits_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         idx_q           <= '0;
         cmd_q           <= '0;
         user_q          <= '0;
         beat_q          <= '0;
         wait_q          <= '0;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_bits_cmd   <= '0;
         resp_bits_rdata <= '0;
         resp_bits_user  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  idx_q  <= req_idx;
                  cmd_q  <= req_bits_cmd;
                  user_q <= req_bits_user;
                  if (req_bits_cmd == CMD_WRITE_BURST) begin
                     state  <= ST_WBURST;
                     beat_q <= 2'd1;
                  end
               end
            end
            ST_WBURST: if (req_fire) beat_q <= beat_q + 2'd1;
            ST_WAIT:   if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
            ST_RESP: begin
               if (resp_fire && last_beat) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  beat_q     <= 2'd0;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (to_wait) begin
            req_ready <= 1'b0;
            state     <= ST_WAIT;
            wait_q    <= WAIT_LOAD;
         end
         if (load_resp) begin
            state           <= ST_RESP;
            beat_q          <= nxt_beat;
            resp_valid      <= 1'b1;
            resp_bits_cmd   <= resp_cmd(src_cmd, nxt_beat);
            resp_bits_rdata <= has_rdata(src_cmd) ? mem_rdata : 64'd0;
            resp_bits_user  <= (state == ST_IDLE) ? req_bits_user : user_q;
         end
      end
   end

endmodule
